// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, sequencer states and message-schedule sigma functions
package sha256_pkg;
    localparam int ROUNDS = 64;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, PRIME, ROUND, ADD, DONE} state_t;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction
endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word message window, loaded word by word then expanded one W_t per advance
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_adv,
    input  logic [31:0] i_word,
    output logic [31:0] o_wt
);
    logic [31:0] r_win [0:15];
    logic [31:0] r_wt;
    logic [31:0] w_new;
    // window holds W_j..W_j+15, so the new word is W_j+16
    assign w_new = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];
    assign o_wt = r_wt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
            r_wt <= '0;
        end else if (i_load || i_adv) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= i_load ? i_word : w_new;
            if (i_adv) r_wt <= r_win[0];
        end
    end
endmodule

// File: rtl/sha256_round_seq.sv
// sha256_round_seq: sequences the SHA-256 round unit over one 512-bit block and maintains the chaining hash
module sha256_round_seq
    import sha256_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [DATA_W-1:0] msg_word,
    input  logic              blk_first,
    output logic              busy,
    output logic              dig_valid,
    output logic [255:0]      digest,
    output logic              ru_run,
    output logic [7:0]        ru_delay,
    output logic [255:0]      ru_state_in,
    output logic [DATA_W-1:0] ru_w,
    output logic [DATA_W-1:0] ru_k,
    input  logic [255:0]      ru_state_out,
    input  logic              ru_done
);
    localparam logic [255:0] IV_VEC = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};
    state_t       r_state;
    logic [3:0]   r_wcnt;
    logic [5:0]   r_t;
    logic         r_first;
    logic [255:0] r_h;
    logic [255:0] r_digest;
    logic [31:0]  r_k;
    logic [255:0] w_sum;
    logic         w_hs;
    logic         w_unused;
    assign w_hs        = msg_valid && msg_ready;
    assign msg_ready   = r_state == IDLE || r_state == LOAD;
    assign busy        = r_state != IDLE;
    assign dig_valid   = r_state == DONE;
    assign ru_run      = r_state == RUN;
    assign ru_delay    = 8'd0;
    assign ru_state_in = r_first ? IV_VEC : r_h;
    assign ru_k        = r_k;
    assign digest      = r_digest;
    assign w_unused    = ru_done;
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) w_sum[32*i +: 32] = r_h[32*i +: 32] + ru_state_out[32*i +: 32];
    end
    sha256_msg_sched u_sched (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_hs),
        .i_adv  (r_state == PRIME || r_state == ROUND),
        .i_word (msg_word),
        .o_wt   (ru_w)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wcnt   <= '0;
            r_t      <= '0;
            r_first  <= 1'b0;
            r_h      <= IV_VEC;
            r_digest <= IV_VEC;
            r_k      <= '0;
        end else begin
            // K is registered one cycle ahead so ru_k is stable for the whole round
            r_k <= K[r_state == ROUND ? r_t + 6'd1 : 6'd0];
            case (r_state)
                IDLE: if (w_hs) begin
                    r_first <= blk_first;
                    r_wcnt  <= 4'd1;
                    r_state <= LOAD;
                end
                LOAD: if (w_hs) begin
                    r_wcnt <= r_wcnt + 4'd1;
                    if (r_wcnt == 4'd15) r_state <= RUN;
                end
                RUN: begin
                    if (r_first) r_h <= IV_VEC;
                    r_state <= PRIME;
                end
                PRIME: begin
                    r_t     <= '0;
                    r_state <= ROUND;
                end
                ROUND: begin
                    r_t <= r_t + 6'd1;
                    if (r_t == 6'(ROUNDS - 1)) r_state <= ADD;
                end
                ADD: begin
                    r_h      <= w_sum;
                    r_digest <= w_sum;
                    r_state  <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_round_seq.sv
// tb_sha256_round_seq: drives message blocks into the sequencer against a behavioural round unit and SHA-256 model
module tb_sha256_round_seq;
    typedef logic [31:0] w16_t [16];
    typedef logic [31:0] w64_t [64];
    localparam logic [255:0] IV_VEC  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         msg_valid = 1'b0;
    logic         blk_first = 1'b0;
    logic [31:0]  msg_word = '0;
    logic         msg_ready, busy, dig_valid, ru_run;
    logic [255:0] digest, ru_state_in;
    logic [7:0]   ru_delay;
    logic [31:0]  ru_w, ru_k;
    logic [255:0] rs_st = '0;
    logic         rs_pend = 1'b0;
    logic         ru_done = 1'b0;
    logic [255:0] tb_h = IV_VEC;
    int           n_chk = 0;
    int           n_fail = 0;
    always #5 clk = ~clk;
    sha256_round_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_word     (msg_word),
        .blk_first    (blk_first),
        .busy         (busy),
        .dig_valid    (dig_valid),
        .digest       (digest),
        .ru_run       (ru_run),
        .ru_delay     (ru_delay),
        .ru_state_in  (ru_state_in),
        .ru_w         (ru_w),
        .ru_k         (ru_k),
        .ru_state_out (rs_st),
        .ru_done      (ru_done)
    );
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ss0(input logic [31:0] x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3); endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction
    function automatic logic [31:0] bs0(input logic [31:0] x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
    function automatic logic [31:0] bs1(input logic [31:0] x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
    function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + bs1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bs0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction
    function automatic void expand(input w16_t b, output w64_t w);
        for (int t = 0; t < 64; t++)
            w[t] = t < 16 ? b[t] : ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
    endfunction
    function automatic logic [255:0] compress(input logic [255:0] h, input w16_t b);
        w64_t w;
        logic [255:0] st, r;
        expand(b, w);
        st = h;
        for (int t = 0; t < 64; t++) st = rnd(st, w[t], KT[t]);
        for (int i = 0; i < 8; i++) r[32*i +: 32] = h[32*i +: 32] + st[32*i +: 32];
        return r;
    endfunction
    // environment round unit: run pulse, load state the following cycle, then one round per clock
    always @(posedge clk) begin
        if (ru_run) rs_pend <= 1'b1;
        else if (rs_pend) begin
            rs_st   <= ru_state_in;
            rs_pend <= 1'b0;
        end else rs_st <= rnd(rs_st, ru_w, ru_k);
    end
    function automatic w16_t abc_blk();
        w16_t b;
        for (int i = 0; i < 16; i++) b[i] = '0;
        b[0]  = 32'h61626380;
        b[15] = 32'h00000018;
        return b;
    endfunction
    function automatic w16_t rand_blk();
        w16_t b;
        for (int i = 0; i < 16; i++) b[i] = $urandom;
        return b;
    endfunction
    task automatic send_words(input w16_t b, input logic first, input bit gaps);
        int g;
        for (int i = 0; i < 16; i++) begin
            if (gaps && i > 0) begin
                msg_valid = 1'b0;
                msg_word  = $urandom;
                repeat (2) @(posedge clk);
                #1;
            end
            msg_valid = 1'b1;
            msg_word  = b[i];
            blk_first = i == 0 ? first : 1'($urandom);
            g = 0;
            while (!msg_ready && g < 200) begin
                @(posedge clk);
                #1;
                g++;
            end
            @(posedge clk);
            #1;
        end
        msg_valid = 1'b0;
    endtask
    task automatic wait_dig(output int n);
        n = 1;
        while (!dig_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_chk++; if (dig_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dig_valid: got %b expected 0", dig_valid); end
        n_chk++; if (msg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_msg_ready: got %b expected 1", msg_ready); end
        n_chk++; if (ru_run !== 1'b0) begin n_fail++; $display("FAIL reset_ru_run: got %b expected 0", ru_run); end
        n_chk++; if (digest !== IV_VEC) begin n_fail++; $display("FAIL reset_digest: got %h expected %h", digest, IV_VEC); end
        n_chk++; if (ru_delay !== 8'd0) begin n_fail++; $display("FAIL reset_ru_delay: got %h expected 00", ru_delay); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tb_h = IV_VEC;
    endtask
    task automatic test_abc();
        int n;
        send_words(abc_blk(), 1'b1, 1'b0);
        n_chk++; if ({ru_run, msg_ready} !== 2'b10) begin n_fail++; $display("FAIL abc_c1_run_ready: got %b expected 10", {ru_run, msg_ready}); end
        wait_dig(n);
        n_chk++; if (n != 68) begin n_fail++; $display("FAIL abc_latency: got %0d expected 68", n); end
        n_chk++; if (digest !== ABC_DIG) begin n_fail++; $display("FAIL abc_digest: got %h expected %h", digest, ABC_DIG); end
        n_chk++; if (digest !== compress(IV_VEC, abc_blk())) begin n_fail++; $display("FAIL abc_model: got %h expected %h", digest, compress(IV_VEC, abc_blk())); end
        tb_h = ABC_DIG;
        @(posedge clk);
        #1;
        n_chk++; if ({dig_valid, busy, msg_ready} !== 3'b001) begin n_fail++; $display("FAIL abc_after_done: got %b expected 001", {dig_valid, busy, msg_ready}); end
    endtask
    task automatic test_two_block();
        w16_t m1, m2;
        int n;
        time t0;
        logic [255:0] d1;
        m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        for (int i = 0; i < 16; i++) m2[i] = '0;
        m2[15] = 32'h000001c0;
        d1 = compress(IV_VEC, m1);
        send_words(m1, 1'b1, 1'b0);
        wait_dig(n);
        t0 = $time;
        n_chk++; if (digest !== d1) begin n_fail++; $display("FAIL two_blk1_digest: got %h expected %h", digest, d1); end
        send_words(m2, 1'b0, 1'b0);
        n_chk++; if (digest !== d1) begin n_fail++; $display("FAIL two_digest_hold: got %h expected %h", digest, d1); end
        wait_dig(n);
        n_chk++; if (($time - t0) / 10 != 84) begin n_fail++; $display("FAIL two_block_period: got %0d expected 84", ($time - t0) / 10); end
        n_chk++; if (digest !== TWO_DIG) begin n_fail++; $display("FAIL two_final_digest: got %h expected %h", digest, TWO_DIG); end
        tb_h = TWO_DIG;
        @(posedge clk);
        #1;
    endtask
    task automatic test_gaps();
        send_words(abc_blk(), 1'b1, 1'b1);
        for (int c = 1; c <= 68; c++) begin
            n_chk++;
            if ({msg_ready, dig_valid} !== {1'b0, c == 68}) begin
                n_fail++;
                $display("FAIL gaps_c%0d_ready_dig: got %b expected %b", c, {msg_ready, dig_valid}, {1'b0, c == 68});
            end
            if (c < 68) begin
                @(posedge clk);
                #1;
            end
        end
        n_chk++; if (digest !== ABC_DIG) begin n_fail++; $display("FAIL gaps_digest: got %h expected %h", digest, ABC_DIG); end
        tb_h = ABC_DIG;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset_mid();
        int n, seen;
        send_words(rand_blk(), 1'b1, 1'b0);
        repeat (32) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_chk++; if (digest !== IV_VEC) begin n_fail++; $display("FAIL midrst_digest: got %h expected %h", digest, IV_VEC); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tb_h = IV_VEC;
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            seen += int'(dig_valid);
            @(posedge clk);
            #1;
        end
        n_chk++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_dig_valid: got %0d pulses expected 0", seen); end
        send_words(abc_blk(), 1'b1, 1'b0);
        wait_dig(n);
        n_chk++; if (n != 68) begin n_fail++; $display("FAIL midrst_abc_latency: got %0d expected 68", n); end
        n_chk++; if (digest !== ABC_DIG) begin n_fail++; $display("FAIL midrst_abc_digest: got %h expected %h", digest, ABC_DIG); end
        tb_h = ABC_DIG;
        @(posedge clk);
        #1;
    endtask
    task automatic test_round_drive();
        w16_t b;
        w64_t w;
        logic first;
        logic [255:0] exp_in, exp_dig;
        for (int rep = 0; rep < 3; rep++) begin
            b = rand_blk();
            first = rep == 1;
            expand(b, w);
            exp_in  = first ? IV_VEC : tb_h;
            exp_dig = compress(exp_in, b);
            send_words(b, first, 1'b0);
            msg_valid = 1'b1;
            for (int c = 1; c <= 68; c++) begin
                n_chk++; if (ru_run !== (c == 1)) begin n_fail++; $display("FAIL drive_c%0d_ru_run: got %b expected %b", c, ru_run, c == 1); end
                if (c <= 2) begin
                    n_chk++; if (ru_state_in !== exp_in) begin n_fail++; $display("FAIL drive_c%0d_state_in: got %h expected %h", c, ru_state_in, exp_in); end
                end
                if (c >= 3 && c <= 66) begin
                    n_chk++; if (ru_w !== w[c-3]) begin n_fail++; $display("FAIL drive_w%0d: got %h expected %h", c - 3, ru_w, w[c-3]); end
                    n_chk++; if (ru_k !== KT[c-3]) begin n_fail++; $display("FAIL drive_k%0d: got %h expected %h", c - 3, ru_k, KT[c-3]); end
                end
                msg_word = $urandom;
                if (c == 68) msg_valid = 1'b0;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            n_chk++; if (dig_valid !== 1'b1) begin n_fail++; $display("FAIL drive_dig_valid: got %b expected 1", dig_valid); end
            n_chk++; if (digest !== exp_dig) begin n_fail++; $display("FAIL drive_digest: got %h expected %h", digest, exp_dig); end
            tb_h = exp_dig;
            @(posedge clk);
            #1;
            n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drive_idle_after: got %b expected 0", busy); end
        end
    endtask
    initial begin
        test_reset();
        test_abc();
        test_two_block();
        test_gaps();
        test_reset_mid();
        test_round_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
